// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: turns one execute-stage access into one or two
// word-aligned memory beats and merges/extends returned load data.
module lsu_align_unit #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int BEW   = 2 * NB;
  localparam int DW2   = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    if (is_store) ok = (f3 <= 3'd2) || (XLEN == 64 && f3 == 3'd3);
    else ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
              (XLEN == 64 && (f3 == 3'd3 || f3 == 3'd6));
    return ok;
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [2:0] f3);
    return (int'(off) + size_of(f3)) > NB;
  endfunction

  // Shift the access to the top of the register, then shift back down
  // arithmetically (signed loads) or logically (unsigned loads).
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input logic [2:0] f3);
    int              sh;
    logic [XLEN-1:0] up;
    sh = (8 * size_of(f3) >= XLEN) ? 0 : XLEN - 8 * size_of(f3);
    up = raw << sh;
    if (f3[2]) return up >> sh;
    return $unsigned($signed(up) >>> sh);
  endfunction

  state_t              state_q, state_d;
  logic                fault_q, fault_d;
  logic                is_store_q, is_store_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic                cross_q, cross_d;
  logic [XLEN-1:0]     rdata0_q, rdata0_d;
  logic [XLEN-1:0]     rdata1_q, rdata1_d;

  logic [OFF_W-1:0]    off;
  logic [ADDR_W-1:0]   base;
  logic [BEW-1:0]      be_wide;
  logic [XLEN-1:0]     wmasked;
  logic [DW2-1:0]      wd_wide;
  logic [DW2-1:0]      rd_wide;

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cross_d    = cross_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          cross_d    = crosses(req_addr[OFF_W-1:0], req_funct3);
          if (!f3_legal(req_is_store, req_funct3) || (cross_d && MISALIGN_SPLIT == 0)) begin
            fault_d = 1'b1;
            state_d = RESP;
          end else begin
            fault_d = 1'b0;
            state_d = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (mem_ack) begin
          rdata0_d = mem_rdata;
          rdata1_d = '0;
          state_d  = cross_q ? BEAT1 : RESP;
        end
      end
      BEAT1: begin
        if (mem_ack) begin
          rdata1_d = mem_rdata;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        fault_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Request/data capture registers carry no reset: they are only read in
  // states reachable after a fresh request has been latched.
  always_ff @(posedge clk) begin
    is_store_q <= is_store_d;
    funct3_q   <= funct3_d;
    addr_q     <= addr_d;
    wdata_q    <= wdata_d;
    cross_q    <= cross_d;
    rdata0_q   <= rdata0_d;
    rdata1_q   <= rdata1_d;
  end

  // Lane placement is computed across a double-width window: the low half
  // feeds beat 0 and the high half is exactly what spills into beat 1.
  always_comb begin
    off     = addr_q[OFF_W-1:0];
    base    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    be_wide = BEW'((1 << size_of(funct3_q)) - 1) << off;
    wmasked = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < size_of(funct3_q)) wmasked[8*i +: 8] = wdata_q[8*i +: 8];
    end
    wd_wide = {{XLEN{1'b0}}, wmasked} << {off, 3'b000};
    rd_wide = {rdata1_q, rdata0_q} >> {off, 3'b000};
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_fault = 1'b0;
    unique case (state_q)
      BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = is_store_q;
        mem_addr  = base;
        mem_be    = be_wide[NB-1:0];
        mem_wdata = wd_wide[XLEN-1:0];
      end
      BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = is_store_q;
        mem_addr  = base + ADDR_W'(NB);
        mem_be    = be_wide[BEW-1:NB];
        mem_wdata = wd_wide[DW2-1:XLEN];
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_fault = fault_q;
        if (!is_store_q && !fault_q) rsp_rdata = extend(rd_wide[XLEN-1:0], funct3_q);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lsu_align_unit.sv
// Scoreboard bench for lsu_align_unit (XLEN=32): a split-enabled instance
// plus a split-disabled instance for the misalignment-fault path.
module tb_lsu_align_unit;
  localparam int XLEN = 32;
  localparam int AW   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            req_valid = 1'b0, ns_req_valid = 1'b0;
  logic            req_is_store = 1'b0;
  logic [2:0]      req_funct3 = '0;
  logic [AW-1:0]   req_addr = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic            mem_ack = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;

  logic req_ready, mem_req, mem_we, rsp_valid, rsp_fault;
  logic [AW-1:0] mem_addr;
  logic [3:0] mem_be;
  logic [XLEN-1:0] mem_wdata, rsp_rdata;
  logic ns_req_ready, ns_mem_req, ns_mem_we, ns_rsp_valid, ns_rsp_fault;
  logic [AW-1:0] ns_mem_addr;
  logic [3:0] ns_mem_be;
  logic [XLEN-1:0] ns_mem_wdata, ns_rsp_rdata;

  lsu_align_unit #(.XLEN(XLEN), .ADDR_W(AW), .MISALIGN_SPLIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault));

  lsu_align_unit #(.XLEN(XLEN), .ADDR_W(AW), .MISALIGN_SPLIT(0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .req_valid(ns_req_valid), .req_ready(ns_req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_req(ns_mem_req), .mem_we(ns_mem_we), .mem_addr(ns_mem_addr),
    .mem_be(ns_mem_be), .mem_wdata(ns_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(ns_rsp_valid), .rsp_rdata(ns_rsp_rdata), .rsp_fault(ns_rsp_fault));

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic            fault;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      exp_t e;
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL rsp_unexpected: got rdata=%h fault=%b, no response pending", rsp_rdata, rsp_fault);
      end else begin
        e = sb_q.pop_front();
        if (rsp_rdata !== e.rdata || rsp_fault !== e.fault)
          $display("FAIL rsp_data: got rdata=%h fault=%b, want rdata=%h fault=%b",
                   rsp_rdata, rsp_fault, e.rdata, e.fault);
        else n_pass++;
      end
    end
  end

  task automatic send(input logic st, input logic [2:0] f3, input logic [AW-1:0] a,
                      input logic [XLEN-1:0] wd);
    req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic serve(input logic [XLEN-1:0] rd, output logic ok, output logic [AW-1:0] a,
                       output logic [3:0] be, output logic [XLEN-1:0] wd, output logic we);
    ok = 1'b0; a = '0; be = '0; wd = '0; we = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mem_req) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (ok) begin
      a = mem_addr; be = mem_be; wd = mem_wdata; we = mem_we;
      mem_rdata = rd; mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = '0;
    end
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 ||
        mem_be !== '0 || mem_wdata !== '0 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_fault !== 1'b0)
      $display("FAIL reset_outputs: got ready=%b req=%b addr=%h be=%h rsp=%b, want 1 0 0 0 0",
               req_ready, mem_req, mem_addr, mem_be, rsp_valid);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lb();
    logic ok, we; logic [AW-1:0] a; logic [3:0] be; logic [XLEN-1:0] wd;
    sb_q.push_back('{rdata: 32'hFFFF_FF80, fault: 1'b0});
    send(1'b0, 3'd0, 32'h1003, '0);
    n_total++;
    if (mem_req !== 1'b1 || req_ready !== 1'b0) $display("FAIL lb_latency: got mem_req=%b ready=%b, want 1 0", mem_req, req_ready);
    else n_pass++;
    serve(32'h80FF_1234, ok, a, be, wd, we);
    n_total++;
    if (!ok || a !== 32'h1000 || be !== 4'h8 || we !== 1'b0)
      $display("FAIL lb_beat: got ok=%b addr=%h be=%h we=%b, want 1 00001000 8 0", ok, a, be, we);
    else n_pass++;
    n_total++;
    if (rsp_valid !== 1'b1) $display("FAIL lb_rsp_timing: got rsp_valid=%b, want 1", rsp_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL lb_rsp_pulse: got rsp_valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
    else n_pass++;
  endtask

  task automatic test_lhu_back_to_back();
    logic ok, we; logic [AW-1:0] a; logic [3:0] be; logic [XLEN-1:0] wd;
    sb_q.push_back('{rdata: 32'h0000_BEEF, fault: 1'b0});
    send(1'b0, 3'd5, 32'h2002, '0);
    serve(32'hBEEF_0000, ok, a, be, wd, we);
    n_total++;
    if (!ok || a !== 32'h2000 || be !== 4'hC) $display("FAIL lhu_beat: got addr=%h be=%h, want 00002000 c", a, be);
    else n_pass++;
    @(posedge clk); #1;
    sb_q.push_back('{rdata: 32'h0000_00F7, fault: 1'b0});
    send(1'b0, 3'd4, 32'h8001, '0);
    serve(32'h0000_F700, ok, a, be, wd, we);
    n_total++;
    if (!ok || a !== 32'h8000 || be !== 4'h2) $display("FAIL lbu_beat: got addr=%h be=%h, want 00008000 2", a, be);
    else n_pass++;
    @(posedge clk); #1;
    sb_q.push_back('{rdata: 32'hDEAD_BEEF, fault: 1'b0});
    send(1'b0, 3'd2, 32'h8004, '0);
    serve(32'hDEAD_BEEF, ok, a, be, wd, we);
    n_total++;
    if (!ok || a !== 32'h8004 || be !== 4'hF) $display("FAIL lw_aligned_beat: got addr=%h be=%h, want 00008004 f", a, be);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    logic ok, we; logic [AW-1:0] a; logic [3:0] be; logic [XLEN-1:0] wd;
    sb_q.push_back('{rdata: '0, fault: 1'b0});
    send(1'b1, 3'd1, 32'h3001, 32'h1234_ABCD);
    serve('0, ok, a, be, wd, we);
    n_total++;
    if (!ok || a !== 32'h3000 || be !== 4'h6 || wd !== 32'h00AB_CD00 || we !== 1'b1)
      $display("FAIL sh_beat: got addr=%h be=%h wdata=%h we=%b, want 00003000 6 00abcd00 1", a, be, wd, we);
    else n_pass++;
    @(posedge clk); #1;
    sb_q.push_back('{rdata: '0, fault: 1'b0});
    send(1'b1, 3'd2, 32'h5003, 32'hA1B2_C3D4);
    serve('0, ok, a, be, wd, we);
    n_total++;
    if (!ok || a !== 32'h5000 || be !== 4'h8 || wd[31:24] !== 8'hD4 || we !== 1'b1)
      $display("FAIL sw_split_beat0: got addr=%h be=%h wdata=%h, want 00005000 8 d4xxxxxx", a, be, wd);
    else n_pass++;
    serve('0, ok, a, be, wd, we);
    n_total++;
    if (!ok || a !== 32'h5004 || be !== 4'h7 || wd[23:0] !== 24'hA1B2C3 || we !== 1'b1)
      $display("FAIL sw_split_beat1: got addr=%h be=%h wdata=%h, want 00005004 7 xxa1b2c3", a, be, wd);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_split_load();
    logic ok, we; logic [AW-1:0] a; logic [3:0] be; logic [XLEN-1:0] wd;
    sb_q.push_back('{rdata: 32'h3344_5566, fault: 1'b0});
    send(1'b0, 3'd2, 32'h4002, '0);
    serve(32'h5566_7788, ok, a, be, wd, we);
    n_total++;
    if (!ok || a !== 32'h4000 || be !== 4'hC) $display("FAIL lw_split_beat0: got addr=%h be=%h, want 00004000 c", a, be);
    else n_pass++;
    n_total++;
    if (rsp_valid !== 1'b0 || mem_req !== 1'b1)
      $display("FAIL lw_split_mid: got rsp_valid=%b mem_req=%b, want 0 1", rsp_valid, mem_req);
    else n_pass++;
    serve(32'h1122_3344, ok, a, be, wd, we);
    n_total++;
    if (!ok || a !== 32'h4004 || be !== 4'h3) $display("FAIL lw_split_beat1: got addr=%h be=%h, want 00004004 3", a, be);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic ok, we, stable; logic [AW-1:0] a; logic [3:0] be; logic [XLEN-1:0] wd;
    sb_q.push_back('{rdata: 32'hFFFF_8001, fault: 1'b0});
    send(1'b0, 3'd1, 32'h6002, '0);
    stable = 1'b1;
    a = mem_addr; be = mem_be;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_req !== 1'b1 || mem_addr !== a || mem_be !== be) stable = 1'b0;
    end
    n_total++;
    if (!stable || a !== 32'h6000 || be !== 4'hC)
      $display("FAIL lh_stall_stable: got stable=%b addr=%h be=%h, want 1 00006000 c", stable, a, be);
    else n_pass++;
    serve(32'h8001_0000, ok, a, be, wd, we);
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_total++;
    if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL idle_ack_ignored: got mem_req=%b rsp_valid=%b ready=%b, want 0 0 1", mem_req, rsp_valid, req_ready);
    else n_pass++;
  endtask

  task automatic test_faults();
    sb_q.push_back('{rdata: '0, fault: 1'b1});
    send(1'b0, 3'd7, 32'h1000, '0);
    n_total++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL illegal_load_t1: got rsp_valid=%b ready=%b mem_req=%b, want 1 0 0", rsp_valid, req_ready, mem_req);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL illegal_load_t2: got mem_req=%b ready=%b, want 0 1", mem_req, req_ready);
    else n_pass++;
    sb_q.push_back('{rdata: '0, fault: 1'b1});
    send(1'b1, 3'd3, 32'h1000, 32'hFFFF_FFFF);
    n_total++;
    if (rsp_valid !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL illegal_sd_xlen32: got rsp_valid=%b mem_req=%b, want 1 0", rsp_valid, mem_req);
    else n_pass++;
    @(posedge clk); #1;
    req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h4002;
    ns_req_valid = 1'b1;
    @(posedge clk); #1;
    ns_req_valid = 1'b0;
    n_total++;
    if (ns_rsp_valid !== 1'b1 || ns_rsp_fault !== 1'b1 || ns_rsp_rdata !== '0 || ns_mem_req !== 1'b0)
      $display("FAIL nosplit_fault: got rsp_valid=%b fault=%b rdata=%h mem_req=%b, want 1 1 0 0",
               ns_rsp_valid, ns_rsp_fault, ns_rsp_rdata, ns_mem_req);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (ns_rsp_valid !== 1'b0 || ns_mem_req !== 1'b0 || ns_req_ready !== 1'b1)
      $display("FAIL nosplit_after: got rsp_valid=%b mem_req=%b ready=%b, want 0 0 1", ns_rsp_valid, ns_mem_req, ns_req_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_beat();
    logic ok, we, quiet; logic [AW-1:0] a; logic [3:0] be; logic [XLEN-1:0] wd;
    send(1'b0, 3'd2, 32'h4002, '0);
    serve(32'h5566_7788, ok, a, be, wd, we);
    @(posedge clk); #1;
    n_total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h4004)
      $display("FAIL rst_in_beat1: got mem_req=%b addr=%h, want 1 00004004", mem_req, mem_addr);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1 || mem_be !== '0)
      $display("FAIL rst_async_drop: got mem_req=%b ready=%b be=%h, want 1->0 1 0", mem_req, req_ready, mem_be);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
    end
    n_total++;
    if (!quiet) $display("FAIL rst_after_release: got activity after reset, want idle with ready=1");
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lhu_back_to_back();
    test_store();
    test_split_load();
    test_stall();
    test_faults();
    test_reset_mid_beat();
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending responses, want 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
